// File: rtl/alu_mul_seq.sv
// Sequential 32-bit shift-and-add multiplier that uses an external alu32 as its only adder.
// Returns the low product word plus zero/negative flags captured from the ALU.
module alu_mul_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] in_A,
   input  logic [31:0] in_B,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] result,
   output logic        result_zero,
   output logic        result_negative,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [2:0]  alu_control,
   input  logic [31:0] alu_out,
   input  logic        alu_zero,
   input  logic        alu_negative
);

   localparam logic [2:0] ALU_ADD = 3'h2;
   localparam logic [2:0] ALU_OR  = 3'h5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FLAG = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_mcand;
   logic [31:0] r_mplier;
   logic [31:0] r_acc;
   logic        r_z;
   logic        r_n;
   logic        w_accept;

   assign w_accept = req_valid & (r_state == ST_IDLE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_next = (in_B != 32'd0) ? ST_RUN : ST_FLAG;
            end
         end
         // Stop as soon as no set multiplier bits remain above the one consumed now.
         ST_RUN: begin
            if (r_mplier[31:1] == 31'd0) begin
               w_state_next = ST_FLAG;
            end
         end
         ST_FLAG: w_state_next = ST_DONE;
         ST_DONE: begin
            if (resp_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready   = 1'b0;
      resp_valid  = 1'b0;
      alu_A       = 32'd0;
      alu_B       = 32'd0;
      alu_control = ALU_ADD;
      case (r_state)
         ST_IDLE: req_ready = 1'b1;
         ST_RUN: begin
            alu_A = r_acc;
            alu_B = r_mcand;
         end
         // OR with zero passes acc through the ALU so its flags describe the result.
         ST_FLAG: begin
            alu_A       = r_acc;
            alu_control = ALU_OR;
         end
         ST_DONE: resp_valid = 1'b1;
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_mcand  <= 32'd0;
         r_mplier <= 32'd0;
         r_acc    <= 32'd0;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_mcand  <= in_A;
                  r_mplier <= in_B;
                  r_acc    <= 32'd0;
               end
            end
            ST_RUN: begin
               if (r_mplier[0]) begin
                  r_acc <= alu_out;
               end
               r_mcand  <= {r_mcand[30:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[31:1]};
            end
            ST_FLAG: begin
               r_z <= alu_zero;
               r_n <= alu_negative;
            end
            default: begin
               r_acc <= r_acc;
            end
         endcase
      end
   end

   assign result          = r_acc;
   assign result_zero     = r_z;
   assign result_negative = r_n;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: behavioural alu32 stand-in, table vectors, random ops against
// a plain-arithmetic model, plus backpressure and mid-run reset sequences.
module tb_alu_mul_seq;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] in_A = 32'd0;
   logic [31:0] in_B = 32'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] result;
   logic        result_zero;
   logic        result_negative;
   logic [31:0] alu_A;
   logic [31:0] alu_B;
   logic [2:0]  alu_control;
   logic [31:0] alu_out;
   logic        alu_zero;
   logic        alu_negative;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   // Combinational alu32 stand-in: ADD and OR are the only codes the block uses.
   assign alu_out      = (alu_control == 3'h5) ? (alu_A | alu_B) : (alu_A + alu_B);
   assign alu_zero     = (alu_out == 32'd0);
   assign alu_negative = alu_out[31];

   alu_mul_seq dut (
      .clock(clock),
      .reset(reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .in_A(in_A),
      .in_B(in_B),
      .resp_valid(resp_valid),
      .resp_ready(resp_ready),
      .result(result),
      .result_zero(result_zero),
      .result_negative(result_negative),
      .alu_A(alu_A),
      .alu_B(alu_B),
      .alu_control(alu_control),
      .alu_out(alu_out),
      .alu_zero(alu_zero),
      .alu_negative(alu_negative)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        n;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int bitlen(input logic [31:0] b);
      for (int i = 31; i >= 0; i--) begin
         if (b[i]) return i + 1;
      end
      return 0;
   endfunction

   // Issues one request and returns once resp_valid is seen (sampled on negedges).
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat,
                         output logic [31:0] res, output logic z, output logic n);
      @(negedge clock);
      chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_alu_ctl", {29'd0, alu_control}, 32'd2);
      req_valid = 1'b1;
      in_A      = a;
      in_B      = b;
      @(negedge clock);
      req_valid = 1'b0;
      in_A      = $urandom;
      in_B      = $urandom;
      lat       = 0;
      while (!resp_valid && lat < 40) begin
         @(negedge clock);
         lat++;
      end
      if (!resp_valid) begin
         total++;
         bad++;
         $display("FAIL timeout: no resp_valid after %0d cycles for a=%h b=%h", lat, a, b);
      end
      res = result;
      z   = result_zero;
      n   = result_negative;
      $display("op a=%h b=%h -> result=%h z=%0b n=%0b lat=%0d", a, b, res, z, n, lat);
   endtask

   initial begin
      vec_t        vecs[5];
      int          lat;
      logic [31:0] res;
      logic        z;
      logic        n;
      logic [31:0] held;

      vecs[0] = '{32'd7,          32'd6,          32'd42,         1'b0, 1'b0, 4};
      vecs[1] = '{32'h00001234,   32'd0,          32'd0,          1'b1, 1'b0, 1};
      vecs[2] = '{32'hFFFFFFFF,   32'd5,          32'hFFFFFFFB,   1'b0, 1'b1, 4};
      vecs[3] = '{32'h00010000,   32'h00010000,   32'd0,          1'b1, 1'b0, 18};
      vecs[4] = '{32'd3,          32'h00000101,   32'h00000303,   1'b0, 1'b0, 10};

      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {30'd0, result_zero, result_negative}, 32'd0);
      chk("rst_alu_ab", alu_A | alu_B, 32'd0);
      chk("rst_alu_ctl", {29'd0, alu_control}, 32'd2);
      repeat (2) @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < 5; i++) begin
         run_op(vecs[i].a, vecs[i].b, lat, res, z, n);
         chk("vec_result", res, vecs[i].res);
         chk("vec_zero", {31'd0, z}, {31'd0, vecs[i].z});
         chk("vec_neg", {31'd0, n}, {31'd0, vecs[i].n});
         chk("vec_latency", lat, vecs[i].lat);
         @(negedge clock);
         chk("vec_back_idle", {30'd0, req_ready, resp_valid}, 32'd2);
      end

      for (int i = 0; i < 25; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [31:0] p;
         a = $urandom;
         b = (i % 7 == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
         p = a * b;
         run_op(a, b, lat, res, z, n);
         chk("rnd_result", res, p);
         chk("rnd_zero", {31'd0, z}, {31'd0, (p == 32'd0)});
         chk("rnd_neg", {31'd0, n}, {31'd0, p[31]});
         chk("rnd_latency", lat, bitlen(b) + 1);
      end

      // Backpressure: DONE holds with stable outputs and ignores a stray request.
      @(negedge clock);
      resp_ready = 1'b0;
      run_op(32'd3, 32'h80000000, lat, res, z, n);
      chk("bp_result", res, 32'h80000000);
      chk("bp_flags", {30'd0, z, n}, 32'd1);
      chk("bp_latency", lat, 33);
      held = res;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         if (i == 1) begin
            req_valid = 1'b1;
            in_A      = 32'd5;
            in_B      = 32'd5;
         end else begin
            req_valid = 1'b0;
         end
         chk("bp_hold_result", result, held);
         chk("bp_hold_hs", {30'd0, req_ready, resp_valid}, 32'd1);
         chk("bp_hold_flags", {30'd0, result_zero, result_negative}, 32'd1);
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         chk("bp_no_queue", {30'd0, req_ready, resp_valid}, 32'd2);
      end

      // Reset during the third RUN cycle drops the operation.
      @(negedge clock);
      req_valid = 1'b1;
      in_A      = 32'd9;
      in_B      = 32'hFF;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      #1;
      chk("mid_rst_hs", {30'd0, req_ready, resp_valid}, 32'd2);
      chk("mid_rst_result", result, 32'd0);
      chk("mid_rst_flags", {30'd0, result_zero, result_negative}, 32'd0);
      chk("mid_rst_alu_ab", alu_A | alu_B, 32'd0);
      chk("mid_rst_alu_ctl", {29'd0, alu_control}, 32'd2);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clock);
         chk("mid_rst_dropped", {30'd0, req_ready, resp_valid}, 32'd2);
      end
      run_op(32'd2, 32'd3, lat, res, z, n);
      chk("post_rst_result", res, 32'd6);
      chk("post_rst_latency", lat, 3);
      chk("post_rst_flags", {30'd0, z, n}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential 32-bit multiplier that drives an external `alu32` instance as its only adder. It uses shift-and-add and returns the low 32 bits of A×B, which are the same for signed and unsigned operands. It also returns zero and negative flags taken from the ALU. It sits between the datapath controller and the shared ALU: a request/response handshake on one side, the ALU operand/control/flag interface on the other.

## Interface
- No parameters. Widths are fixed at 32; ALU control codes are fixed: ADD = 3'h2, OR = 3'h5.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request; high only in IDLE.
- `in_A`  in  32  multiplicand; sampled only at the accept edge.
- `in_B`  in  32  multiplier; sampled only at the accept edge.
- `resp_valid`  out  1  result available; high only in DONE.
- `resp_ready`  in  1  consumer takes the result.
- `result`  out  32  (A×B) mod 2^32.
- `result_zero`  out  1  result == 0.
- `result_negative`  out  1  result[31].
- `alu_A`  out  32  ALU operand A.
- `alu_B`  out  32  ALU operand B.
- `alu_control`  out  3  ALU operation select.
- `alu_out`  in  32  ALU result (combinational from `alu_A`, `alu_B`, `alu_control`).
- `alu_zero`  in  1  ALU zero flag.
- `alu_negative`  in  1  ALU negative flag.
- The ALU overflow flag is not connected.

## Operation
- Internal registers:
  - `mcand` (32): multiplicand, shifted left each RUN cycle.
  - `mplier` (32): multiplier, shifted right each RUN cycle.
  - `acc` (32): running product.
  - `z`, `n`: captured flags.
  - `state`: one of IDLE, RUN, FLAG, DONE.
- IDLE:
  - `req_ready`=1.
  - ALU driven with A=0, B=0, control=ADD.
  - On `req_valid` & `req_ready` at an edge: `mcand`←`in_A`, `mplier`←`in_B`, `acc`←0.
  - Next state is RUN if `in_B`≠0, else FLAG.
- RUN, one multiplier bit per cycle:
  - ALU driven with A=`acc`, B=`mcand`, control=ADD.
  - If `mplier[0]`: `acc`←`alu_out`; otherwise `acc` holds.
  - `mcand`←`mcand`<<1 (zero fill, upper bit discarded).
  - `mplier`←`mplier`>>1 (logical).
  - If `mplier[31:1]`==0, next state is FLAG; else stay in RUN.
- FLAG, exactly one cycle:
  - ALU driven with A=`acc`, B=0, control=OR.
  - `z`←`alu_zero`, `n`←`alu_negative`; next state DONE.
- DONE:
  - `resp_valid`=1; `result`=`acc`, `result_zero`=`z`, `result_negative`=`n`.
  - ALU driven as in IDLE.
  - On `resp_ready` at an edge: next state IDLE. Registers keep their values; outputs are don't-care outside DONE.
- Arithmetic: every add is modulo 2^32 and ALU carry/overflow is ignored, so the result is the correct low word for both signed and unsigned interpretations.
- Early termination: RUN stops once the remaining multiplier bits are zero. Leading zero bits of B cost no cycles.

## Timing
- RUN length: k = bit-length of B, i.e. index of highest set bit + 1; k=0 for B=0, k=32 for B[31]=1.
- Latency: accept edge → `resp_valid` high after k+1 cycles (k RUN cycles + 1 FLAG cycle). Range is 1 to 33 cycles.
- Throughput:
  - One operation in flight.
  - `req_ready`=0 from the accept edge until the cycle after the response handshake.
  - The minimum gap between accepts is k+3 cycles.
- Backpressure:
  - With `resp_ready` low, DONE holds indefinitely.
  - `result`, `result_zero` and `result_negative` stay stable and `resp_valid` stays high.
- `req_valid` outside IDLE is ignored and not queued. Changes to `in_A`/`in_B` after the accept edge have no effect.
- Reset values, and behaviour on reset in any state including mid-RUN:
  - state=IDLE; all registers 0.
  - `req_ready`=1, `resp_valid`=0, `result`=0, `result_zero`=0, `result_negative`=0.
  - `alu_A`=0, `alu_B`=0, `alu_control`=ADD.
  - An in-flight operation is dropped with no response.
- The ALU path is purely combinational. The block assumes `alu_out` and the ALU flags settle within the same cycle the operands are driven.

## Test plan
- A=7, B=6, `resp_ready`=1 → k=3; `resp_valid` 4 cycles after accept; `result`=42, zero=0, negative=0; IDLE the next cycle.
- A=0x00001234, B=0 → no RUN cycles; `resp_valid` 1 cycle after accept; `result`=0, zero=1, negative=0.
- A=0xFFFFFFFF, B=5 → `result`=0xFFFFFFFB, negative=1, zero=0, latency 4.
- A=0x00010000, B=0x00010000 → product wraps; `result`=0, zero=1; latency 18 cycles.
- A=3, B=0x80000000 → latency 33, `result`=0x80000000, negative=1. Hold `resp_ready` low for 5 cycles: outputs stable, `req_ready`=0 throughout, and a `req_valid` pulse during that time is ignored.
- Start A=9, B=0xFF, then drop `reset` low during RUN cycle 3 → all outputs at reset values immediately. After reset release, A=2, B=3 → `result`=6 with latency 3.
